// File: rtl/gmac_tx_arbiter.sv
// Round-robin arbiter merging NUM_CH byte-stream sources into one registered MAC transmit stream.
// Defining GMAC_ARB_TIMEOUT_EN adds a grant timeout that revokes a grant left waiting for SoF.
module gmac_tx_arbiter #(
   parameter int NUM_CH        = 3,
   parameter int IFG_CYCLES    = 12,
   parameter int MAX_FRAME     = 1518,
   parameter int GRANT_TIMEOUT = 255
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic [NUM_CH-1:0]     ReqIn,
   input  logic [NUM_CH-1:0]     ValIn,
   input  logic [NUM_CH-1:0]     SoFIn,
   input  logic [NUM_CH-1:0]     EoFIn,
   input  logic [8*NUM_CH-1:0]   DataIn,
   output logic [NUM_CH-1:0]     ReqConfirm,
   output logic                  TX_VAL,
   output logic                  TX_SOF,
   output logic                  TX_EOF,
   output logic                  TX_ERR,
   output logic [7:0]            TX_DATA,
   output logic                  BUSY,
   output logic [1:0]            dbg_state
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, XFER = 2'd2, GAP = 2'd3} state_t;

   // Handshake: a source owns the output while its ReqConfirm bit is high; every cycle with its
   // ValIn high transfers one byte, with no back-pressure, and appears on TX_* one cycle later.
   state_t            state, state_nxt;
   logic [CH_W-1:0]   grant_idx, grant_idx_nxt;
   logic [CH_W-1:0]   last_grant, last_grant_nxt;
   logic [CH_W-1:0]   rr_idx;
   logic [NUM_CH-1:0] confirm_nxt;
   logic [13:0]       byte_cnt, byte_cnt_nxt, cnt_inc;
   logic [7:0]        gap_cnt, gap_cnt_nxt;
   logic              val_nxt, sof_nxt, eof_nxt, err_nxt;
   logic [7:0]        data_nxt;
   logic              g_req, g_val, g_sof, g_eof, timeout_hit;
   logic [7:0]        g_data;

   function automatic logic [CH_W-1:0] rr_pos(input logic [CH_W-1:0] base, input int k);
      return CH_W'((int'(base) + k) % NUM_CH);
   endfunction

   assign g_req   = ReqIn[grant_idx];
   assign g_val   = ValIn[grant_idx];
   assign g_sof   = SoFIn[grant_idx];
   assign g_eof   = EoFIn[grant_idx];
   assign g_data  = DataIn[{grant_idx, 3'b000} +: 8];
   assign cnt_inc = byte_cnt + 14'd1;

   // Smallest offset from last_grant+1 wins, so the loop overwrites from the far end inward.
   always_comb begin
      rr_idx = last_grant;
      for (int k = NUM_CH; k >= 1; k--) begin
         if (ReqIn[rr_pos(last_grant, k)]) rr_idx = rr_pos(last_grant, k);
      end
   end

`ifdef GMAC_ARB_TIMEOUT_EN
   logic [15:0] to_cnt;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)              to_cnt <= '0;
      else if (state != GRANT) to_cnt <= '0;
      else                     to_cnt <= to_cnt + 16'd1;
   end

   assign timeout_hit = (to_cnt == 16'(GRANT_TIMEOUT - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_nxt      = state;
      grant_idx_nxt  = grant_idx;
      last_grant_nxt = last_grant;
      confirm_nxt    = ReqConfirm;
      byte_cnt_nxt   = byte_cnt;
      gap_cnt_nxt    = gap_cnt;
      val_nxt        = 1'b0;
      sof_nxt        = 1'b0;
      eof_nxt        = 1'b0;
      err_nxt        = 1'b0;
      data_nxt       = 8'h00;
      case (state)
         IDLE: begin
            if (|ReqIn) begin
               grant_idx_nxt       = rr_idx;
               confirm_nxt         = '0;
               confirm_nxt[rr_idx] = 1'b1;
               state_nxt           = GRANT;
            end
         end
         GRANT: begin
            if (!g_req) begin
               confirm_nxt = '0;
               state_nxt   = IDLE;
            end else if (g_val && g_sof) begin
               val_nxt      = 1'b1;
               sof_nxt      = 1'b1;
               eof_nxt      = g_eof;
               data_nxt     = g_data;
               byte_cnt_nxt = 14'd1;
               if (g_eof) begin
                  confirm_nxt    = '0;
                  last_grant_nxt = grant_idx;
                  gap_cnt_nxt    = 8'd0;
                  state_nxt      = GAP;
               end else begin
                  state_nxt = XFER;
               end
            end else if (timeout_hit) begin
               confirm_nxt    = '0;
               last_grant_nxt = grant_idx;
               state_nxt      = IDLE;
            end
         end
         XFER: begin
            if (g_val) begin
               val_nxt      = 1'b1;
               data_nxt     = g_data;
               byte_cnt_nxt = cnt_inc;
               // A byte reaching the size limit without EoF closes the frame as errored.
               if (g_eof || cnt_inc == 14'(MAX_FRAME)) begin
                  eof_nxt        = 1'b1;
                  err_nxt        = !g_eof;
                  confirm_nxt    = '0;
                  last_grant_nxt = grant_idx;
                  gap_cnt_nxt    = 8'd0;
                  state_nxt      = GAP;
               end
            end
         end
         GAP: begin
            if (gap_cnt == 8'(IFG_CYCLES - 1)) state_nxt   = IDLE;
            else                               gap_cnt_nxt = gap_cnt + 8'd1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state      <= IDLE;
         grant_idx  <= '0;
         last_grant <= CH_W'(NUM_CH - 1);
         ReqConfirm <= '0;
         byte_cnt   <= '0;
         gap_cnt    <= '0;
         TX_VAL     <= 1'b0;
         TX_SOF     <= 1'b0;
         TX_EOF     <= 1'b0;
         TX_ERR     <= 1'b0;
         TX_DATA    <= 8'h00;
      end else begin
         state      <= state_nxt;
         grant_idx  <= grant_idx_nxt;
         last_grant <= last_grant_nxt;
         ReqConfirm <= confirm_nxt;
         byte_cnt   <= byte_cnt_nxt;
         gap_cnt    <= gap_cnt_nxt;
         TX_VAL     <= val_nxt;
         TX_SOF     <= sof_nxt;
         TX_EOF     <= eof_nxt;
         TX_ERR     <= err_nxt;
         TX_DATA    <= data_nxt;
      end
   end

   assign BUSY      = (state != IDLE);
   assign dbg_state = state;

endmodule

// File: tb/tb_gmac_tx_arbiter.sv
// Directed bench for gmac_tx_arbiter: single-channel frames, size limit, grant release,
// grant timeout (or indefinite wait), asynchronous reset and round-robin rotation.
module tb_gmac_tx_arbiter;
   localparam int NUM_CH = 3;
   localparam int IFG    = 12;
   localparam int MAXF   = 64;
   localparam int GTO    = 10;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GRANT = 2'd1;
   localparam logic [1:0] ST_GAP   = 2'd3;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  req   = '0;
   logic [2:0]  val   = '0;
   logic [2:0]  sof   = '0;
   logic [2:0]  eof   = '0;
   logic [23:0] data  = '0;
   logic [2:0]  confirm;
   logic        tx_val, tx_sof, tx_eof, tx_err, busy;
   logic [7:0]  tx_data;
   logic [1:0]  dbg_state;
   logic [11:0] tx_bus;
   int          n_cmp = 0;
   int          n_err = 0;

   assign tx_bus = {tx_val, tx_sof, tx_eof, tx_err, tx_data};

   gmac_tx_arbiter #(
      .NUM_CH(NUM_CH), .IFG_CYCLES(IFG), .MAX_FRAME(MAXF), .GRANT_TIMEOUT(GTO)
   ) dut (
      .CLK(clk), .RST_N(rst_n), .ReqIn(req), .ValIn(val), .SoFIn(sof), .EoFIn(eof),
      .DataIn(data), .ReqConfirm(confirm), .TX_VAL(tx_val), .TX_SOF(tx_sof),
      .TX_EOF(tx_eof), .TX_ERR(tx_err), .TX_DATA(tx_data), .BUSY(busy),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_inputs();
      val  = '0;
      sof  = '0;
      eof  = '0;
      data = '0;
   endtask

   task automatic wait_grant();
      int n = 0;
      while (confirm == 3'b000 && n < 40) begin
         tick();
         n++;
      end
      check("grant_arrives", {31'd0, confirm != 3'b000}, 32'd1);
   endtask

   // start = GAP observations already consumed before the call.
   task automatic wait_gap(input int start);
      int n    = start;
      int loud = 0;
      while (dbg_state == ST_GAP && n < 300) begin
         if (n > 0 && tx_val) loud++;
         tick();
         n++;
      end
      check("gap_len", n, IFG);
      check("gap_quiet", loud, 0);
   endtask

   // Non-granted channels carry junk bytes that must never reach the output.
   task automatic send_frame(input int ch, input int len, input logic [7:0] base,
                             input logic [7:0] step, input bit sof_all);
      logic [11:0] exp;
      for (int i = 0; i < len; i++) begin
         for (int c = 0; c < NUM_CH; c++) begin
            val[c]        = 1'b1;
            sof[c]        = (c == ch) && (i == 0 || sof_all);
            eof[c]        = (c == ch) && (i == len - 1);
            data[c*8 +: 8] = (c == ch) ? 8'(base + step * i) : 8'hEE;
         end
         tick();
         exp = {1'b1, (i == 0), (i == len - 1), 1'b0, 8'(base + step * i)};
         check("tx_byte", tx_bus, exp);
      end
      check("confirm_clear", confirm, 0);
      check("state_gap", dbg_state, ST_GAP);
      clear_inputs();
   endtask

   initial begin
      logic [11:0] exp;
      int          n;
      int          loud;
      int          ch;

      clear_inputs();
      repeat (3) tick();
      check("rst_tx", tx_bus, 0);
      check("rst_confirm", confirm, 0);
      check("rst_busy", busy, 0);
      check("rst_state", dbg_state, ST_IDLE);
      rst_n = 1'b1;
      tick();

      // Channel 1 alone: AA(SoF) BB CC(EoF)
      req = 3'b010;
      tick();
      check("ch1_grant", confirm, 3'b010);
      check("ch1_busy", busy, 1);
      send_frame(1, 3, 8'hAA, 8'h11, 1'b0);
      req = 3'b000;
      wait_gap(0);

      // One-byte frame on channel 0
      req = 3'b001;
      wait_grant();
      check("one_grant", confirm, 3'b001);
      send_frame(0, 1, 8'h5A, 8'h00, 1'b0);
      req = 3'b000;
      wait_gap(0);

      // 70 bytes without EoF against a 64-byte limit
      req = 3'b001;
      wait_grant();
      check("max_grant", confirm, 3'b001);
      for (int i = 0; i < 70; i++) begin
         val[0]    = 1'b1;
         sof[0]    = (i == 0);
         eof[0]    = 1'b0;
         data[7:0] = 8'(i + 1);
         tick();
         if (i < MAXF) exp = {1'b1, (i == 0), (i == MAXF - 1), (i == MAXF - 1), 8'(i + 1)};
         else          exp = '0;
         check("max_byte", tx_bus, exp);
         if (i == MAXF - 1) begin
            check("max_state", dbg_state, ST_GAP);
            check("max_confirm", confirm, 0);
         end
      end
      req = 3'b000;
      clear_inputs();
      wait_gap(70 - MAXF);

      // Grant ignores ValIn without SoF, then released before SoF: back to IDLE, no GAP
      req = 3'b100;
      wait_grant();
      check("rel_grant", confirm, 3'b100);
      val[2]      = 1'b1;
      data[23:16] = 8'h77;
      tick();
      tick();
      check("rel_noval", tx_val, 0);
      check("rel_state_grant", dbg_state, ST_GRANT);
      clear_inputs();
      req = 3'b000;
      tick();
      check("rel_confirm", confirm, 0);
      check("rel_state_idle", dbg_state, ST_IDLE);

      // Channel 2 granted ahead of channel 0 but never starts a frame
      req = 3'b101;
      wait_grant();
      check("to_grant", confirm, 3'b100);
`ifdef GMAC_ARB_TIMEOUT_EN
      n    = 0;
      loud = 0;
      while (confirm == 3'b100 && n < 50) begin
         if (tx_val) loud++;
         n++;
         tick();
      end
      check("to_len", n, GTO);
      check("to_noval", loud, 0);
      tick();
      check("to_next_ch0", confirm, 3'b001);
`else
      repeat (40) tick();
      check("wait_confirm", confirm, 3'b100);
      check("wait_state", dbg_state, ST_GRANT);
      req = 3'b001;
      tick();
      check("wait_drop", confirm, 0);
      tick();
      check("wait_next_ch0", confirm, 3'b001);
`endif
      req = 3'b000;
      tick();
      tick();

      // Reset pulsed while byte 3 of a channel 1 frame is on the input
      req = 3'b010;
      wait_grant();
      check("mid_grant", confirm, 3'b010);
      for (int i = 0; i < 2; i++) begin
         val[1]     = 1'b1;
         sof[1]     = (i == 0);
         data[15:8] = 8'(8'h30 + i);
         tick();
         check("mid_byte", tx_bus, {1'b1, (i == 0), 1'b0, 1'b0, 8'(8'h30 + i)});
      end
      sof[1]     = 1'b0;
      data[15:8] = 8'h32;
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_async_tx", tx_bus, 0);
      check("mid_async_confirm", confirm, 0);
      check("mid_async_busy", busy, 0);
      clear_inputs();
      req = 3'b011;
      tick();
      rst_n = 1'b1;
      tick();
      check("mid_ch0_first", confirm, 3'b001);
      req = 3'b000;
      tick();
      tick();

      // All channels requesting: rotation 0,1,2,0; channel 2 also raises SoF mid-frame
      req = 3'b111;
      for (int f = 0; f < 4; f++) begin
         ch = f % NUM_CH;
         wait_grant();
         check("rr_grant", confirm, 1 << ch);
         send_frame(ch, 4, 8'(16 * f), 8'h01, ch == 2);
         wait_gap(0);
      end
      req = 3'b000;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1);
   end

endmodule
